tim_etb_router: RTL and testbench
=================================

TIM_ETB_ROUTER -- requirements
Module: tim_etb_router

Interface
REQ-001 SHALL have ports pclk (input, 1, sole clock) and preset (input, 1); one clock, reset asynchronous and active-high.
REQ-002 SHALL have APB slave ports psel, penable, pwrite (input, 1), paddr (input, 8, byte address), pwdata (input, 32) and prdata (output, 32); no pready or pslverr, zero wait states.
REQ-003 SHALL have trig_src (input, 4, level event sources synchronous to pclk): bit0 tim1_etb_trig, bit1 tim2_etb_trig, bits 3:2 external sources.
REQ-004 SHALL have etb_tim1_trig_en_on, etb_tim1_trig_en_off, etb_tim2_trig_en_on and etb_tim2_trig_en_off (output, 1 each, single-cycle command pulses to the timer block).
REQ-005 SHALL have etb_intr (output, 1, level interrupt).

Function
REQ-006 SHALL provide 4 identical channels, n = 0..3.
REQ-007 SHALL implement registers: 0x00 CTRL ([0] GEN global enable, [7:4] IE per-channel interrupt enable); 0x04 SWTRIG (write-only, write 1 to bit n, reads 0); 0x08 STATUS ([3:0] sticky fired flags, write-1-to-clear); 0x10+4n CHn_CFG ([1:0] SRC, [2] CHEN, [3] DEST 0=tim1 1=tim2, [4] ACT 0=on 1=off).
REQ-008 SHALL write on psel & penable & pwrite; unused and unmapped bits SHALL read 0 and ignore writes.
REQ-009 SHALL drive prdata combinationally during psel & ~pwrite, and 0 otherwise.
REQ-010 SHALL keep a per-source previous-value register updated every cycle regardless of enables.
REQ-011 SHALL detect a hardware event for channel n when trig_src[SRC] = 1 and its previous value = 0.
REQ-012 SHALL detect a software event for channel n in the cycle after a write of 1 to SWTRIG bit n.
REQ-013 SHALL treat an event as a fire only when GEN = 1 and CHEN = 1; all other events are discarded with no pulse and no status.
REQ-014 SHALL register outputs: a fire detected in cycle k pulses the selected DEST/ACT output high for exactly cycle k+1.
REQ-015 SHALL set STATUS[n] in cycle k+1 on a fire.
REQ-016 SHALL OR together same-cycle fires of several channels onto the same output.
REQ-017 SHALL suppress the on pulse when on and off fires to the same timer coincide; off wins, and both STATUS bits are set.
REQ-018 SHALL let set win over clear when a STATUS W1C and a fire of the same bit coincide.
REQ-019 SHALL use the old config for event evaluation in the cycle a CHn_CFG write completes.
REQ-020 SHALL NOT pulse for a source already high when CHEN or GEN is set; only a later fresh rising edge fires.
REQ-021 SHALL merge a software event and a hardware edge on the same channel in the same cycle into one pulse.
REQ-022 SHALL drive etb_intr = |(STATUS & IE), registered from the STATUS/IE registers.

Reset
REQ-023 SHALL, while preset = 1, clear all registers, previous-value registers and pending software triggers, and hold all outputs and prdata at 0.
REQ-024 SHALL discard any pulse pending at reset assertion; the first possible pulse is 2 cycles after reset deassertion.

Structure
REQ-025 SHALL place the channel count (4), register offsets, field bit positions and the DEST/ACT encodings in the shared package etb_pkg.
REQ-026 SHALL instantiate 4 copies of sub-module etb_chan (source mux, edge detect, fire qualification, decoded on/off strobes); the top holds the APB decode, STATUS, output ORing/priority and output registers.

Verification
REQ-027 SHALL test: CH0 SRC=0 CHEN=1 DEST=1 ACT=0, GEN=1, trig_src[0] rising at cycle 10 -> etb_tim2_trig_en_on high in cycle 11 only, STATUS=0x1.
REQ-028 SHALL test: CH1 DEST=0 ACT=1, write SWTRIG=0x2 -> etb_tim1_trig_en_off single pulse 2 cycles after the write access, SWTRIG reads 0.
REQ-029 SHALL test: CH0 tim1 on and CH2 tim1 off with the same source edge -> only etb_tim1_trig_en_off pulses, STATUS=0x5.
REQ-030 SHALL test: source held high, then CHEN set -> no pulse; source falls and rises -> one pulse.
REQ-031 SHALL test: IE=0x1, STATUS[0] set -> etb_intr=1; W1C 0x1 in the same cycle as a new CH0 fire -> STATUS[0] stays 1.
REQ-032 SHALL test: assert preset in the cycle a fire is detected -> no output pulse, all registers read 0 after release.

Source files
------------

// File: rtl/etb_pkg.sv
// etb_pkg: shared channel count, register map, field layout and DEST/ACT encodings
package etb_pkg;
  localparam int NCH = 4;
  localparam int NSRC = 4;
  localparam int CFG_W = 5;
  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_SWTRIG = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_CFG0 = 8'h10;
  localparam int CTRL_GEN = 0;
  localparam int CTRL_IE = 4;
  typedef enum logic {DEST_TIM1 = 1'b0, DEST_TIM2 = 1'b1} dest_e;
  typedef enum logic {ACT_ON = 1'b0, ACT_OFF = 1'b1} act_e;
  typedef struct packed {
    act_e act;
    dest_e dest;
    logic chen;
    logic [1:0] src;
  } chan_cfg_t;
  function automatic logic [7:0] cfg_addr(input int n);
    return ADDR_CFG0 + 8'(n * 4);
  endfunction
endpackage

// File: rtl/tim_etb_router_if.sv
// tim_etb_router_if: zero-wait APB bus carrying the router register accesses
interface tim_etb_router_if;
  logic psel;
  logic penable;
  logic pwrite;
  logic [7:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  modport master(output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/etb_chan.sv
// etb_chan: one routing channel; selects a source, detects its rising edge, qualifies and decodes the fire
module etb_chan
  import etb_pkg::*;
(
  input  logic [NSRC-1:0] trig_src,
  input  logic [NSRC-1:0] src_prev,
  input  logic            sw,
  input  logic            gen,
  input  chan_cfg_t       cfg,
  output logic            fire,
  output logic            tim1_on,
  output logic            tim1_off,
  output logic            tim2_on,
  output logic            tim2_off
);
  // a software request and a hardware edge in the same cycle collapse into one fire
  always_comb begin
    fire = gen & cfg.chen & ((trig_src[cfg.src] & ~src_prev[cfg.src]) | sw);
    tim1_on = fire & (cfg.dest == DEST_TIM1) & (cfg.act == ACT_ON);
    tim1_off = fire & (cfg.dest == DEST_TIM1) & (cfg.act == ACT_OFF);
    tim2_on = fire & (cfg.dest == DEST_TIM2) & (cfg.act == ACT_ON);
    tim2_off = fire & (cfg.dest == DEST_TIM2) & (cfg.act == ACT_OFF);
  end
endmodule

// File: rtl/tim_etb_router.sv
// tim_etb_router: routes trigger events from four channels to timer on/off command pulses
module tim_etb_router
  import etb_pkg::*;
(
  input  logic                pclk,
  input  logic                preset,
  tim_etb_router_if.slave     apb,
  input  logic [NSRC-1:0]     trig_src,
  output logic                etb_tim1_trig_en_on,
  output logic                etb_tim1_trig_en_off,
  output logic                etb_tim2_trig_en_on,
  output logic                etb_tim2_trig_en_off,
  output logic                etb_intr
);
  logic gen;
  logic [NCH-1:0] ie, status, sw_pend, fire, t1_on, t1_off, t2_on, t2_off;
  logic [NSRC-1:0] src_prev;
  chan_cfg_t cfg [NCH];
  logic wr, rd, unused_pwdata;
  assign wr = apb.psel & apb.penable & apb.pwrite;
  assign rd = apb.psel & ~apb.pwrite & ~preset;
  assign unused_pwdata = ^apb.pwdata[31:CTRL_IE+NCH];
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    etb_chan u_chan (
      .trig_src (trig_src),
      .src_prev (src_prev),
      .sw       (sw_pend[g]),
      .gen      (gen),
      .cfg      (cfg[g]),
      .fire     (fire[g]),
      .tim1_on  (t1_on[g]),
      .tim1_off (t1_off[g]),
      .tim2_on  (t2_on[g]),
      .tim2_off (t2_off[g])
    );
  end
  // register file, source history and one-cycle software trigger requests
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      gen <= 1'b0;
      ie <= '0;
      status <= '0;
      sw_pend <= '0;
      src_prev <= '0;
      for (int c = 0; c < NCH; c++) cfg[c] <= '0;
    end else begin
      src_prev <= trig_src;
      sw_pend <= (wr && apb.paddr == ADDR_SWTRIG) ? apb.pwdata[NCH-1:0] : '0;
      status <= (status & ~((wr && apb.paddr == ADDR_STATUS) ? apb.pwdata[NCH-1:0] : '0)) | fire;
      if (wr && apb.paddr == ADDR_CTRL) begin
        gen <= apb.pwdata[CTRL_GEN];
        ie <= apb.pwdata[CTRL_IE +: NCH];
      end
      for (int c = 0; c < NCH; c++)
        if (wr && apb.paddr == cfg_addr(c)) cfg[c] <= chan_cfg_t'(apb.pwdata[CFG_W-1:0]);
    end
  end
  // registered command pulses; an off to a timer masks a coincident on to the same timer
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      {etb_tim1_trig_en_on, etb_tim1_trig_en_off, etb_tim2_trig_en_on, etb_tim2_trig_en_off, etb_intr} <= '0;
    end else begin
      etb_tim1_trig_en_on <= |t1_on & ~|t1_off;
      etb_tim1_trig_en_off <= |t1_off;
      etb_tim2_trig_en_on <= |t2_on & ~|t2_off;
      etb_tim2_trig_en_off <= |t2_off;
      etb_intr <= |(status & ie);
    end
  end
  // read mux, quiet outside read transfers
  always_comb begin
    apb.prdata = '0;
    if (rd) begin
      apb.prdata = apb.paddr == ADDR_CTRL ? (32'(ie) << CTRL_IE) | 32'(gen) :
                   apb.paddr == ADDR_STATUS ? 32'(status) : '0;
      for (int c = 0; c < NCH; c++)
        if (apb.paddr == cfg_addr(c)) apb.prdata = 32'(cfg[c]);
    end
  end
endmodule

// File: tb/tb_tim_etb_router.sv
// tb_tim_etb_router: directed and random checks of the trigger router against a cycle reference model
module tb_tim_etb_router;
  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic [3:0] trig_src = '0;
  logic t1on, t1off, t2on, t2off, intr;
  int n_assert = 0;
  int n_fail = 0;
  int cnt [4];
  logic m_gen;
  logic [3:0] m_ie, m_status, m_sw, m_prev, e_out;
  logic [4:0] m_cfg [4];
  logic e_intr;
  string nm [4] = '{"tim1_on", "tim1_off", "tim2_on", "tim2_off"};
  logic [7:0] al [9] = '{8'h00, 8'h04, 8'h08, 8'h0c, 8'h10, 8'h14, 8'h18, 8'h1c, 8'h20};

  tim_etb_router_if bus();
  tim_etb_router dut (
    .pclk                 (pclk),
    .preset               (preset),
    .apb                  (bus),
    .trig_src             (trig_src),
    .etb_tim1_trig_en_on  (t1on),
    .etb_tim1_trig_en_off (t1off),
    .etb_tim2_trig_en_on  (t2on),
    .etb_tim2_trig_en_off (t2off),
    .etb_intr             (intr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [7:0] a);
    mread = '0;
    if (a == 8'h00) mread = {24'b0, m_ie, 3'b0, m_gen};
    if (a == 8'h08) mread = {28'b0, m_status};
    for (int c = 0; c < 4; c++) if (a == 8'(16 + 4 * c)) mread = {27'b0, m_cfg[c]};
  endfunction

  // one clock: the model consumes the inputs seen at the edge, outputs are checked mid-cycle
  task automatic tick();
    logic [3:0] f, h, o;
    logic [1:0] s;
    logic w;
    @(posedge pclk);
    if (preset) begin
      m_gen = 0; m_ie = 0; m_status = 0; m_sw = 0; m_prev = 0; e_out = 0; e_intr = 0;
      for (int c = 0; c < 4; c++) m_cfg[c] = 0;
    end else begin
      w = bus.psel & bus.penable & bus.pwrite;
      f = '0;
      h = '0;
      for (int c = 0; c < 4; c++) begin
        s = m_cfg[c][1:0];
        f[c] = m_gen & m_cfg[c][2] & ((trig_src[s] & ~m_prev[s]) | m_sw[c]);
        if (f[c]) h[{m_cfg[c][3], m_cfg[c][4]}] = 1'b1;
      end
      e_out = {h[3], h[2] & ~h[3], h[1], h[0] & ~h[1]};
      e_intr = |(m_status & m_ie);
      m_status = (m_status & ~((w && bus.paddr == 8'h08) ? bus.pwdata[3:0] : 4'h0)) | f;
      m_sw = (w && bus.paddr == 8'h04) ? bus.pwdata[3:0] : 4'h0;
      if (w && bus.paddr == 8'h00) begin
        m_gen = bus.pwdata[0];
        m_ie = bus.pwdata[7:4];
      end
      for (int c = 0; c < 4; c++) if (w && bus.paddr == 8'(16 + 4 * c)) m_cfg[c] = bus.pwdata[4:0];
      m_prev = trig_src;
    end
    @(negedge pclk);
    o = {t2off, t2on, t1off, t1on};
    for (int i = 0; i < 4; i++) begin
      chk(nm[i], 32'(o[i]), 32'(e_out[i]));
      cnt[i] += int'(o[i]);
    end
    chk("etb_intr", 32'(intr), 32'(e_intr));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.psel = 1; bus.pwrite = 1; bus.penable = 0; bus.paddr = a; bus.pwdata = d;
    tick();
    bus.penable = 1;
    tick();
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag, input bit mdl = 0);
    bus.psel = 1; bus.pwrite = 0; bus.penable = 0; bus.paddr = a;
    tick();
    bus.penable = 1;
    #1;
    chk(tag, bus.prdata, mdl ? mread(a) : exp);
    tick();
    bus.psel = 0; bus.penable = 0;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  initial begin
    logic [7:0] a;
    logic [31:0] d;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    tick(); tick();
    chk("prdata_in_reset", bus.prdata, 32'h0);
    preset = 0;
    tick();
    rd(8'h00, 32'h0, "ctrl_reset");
    rd(8'h08, 32'h0, "status_reset");
    rd(8'h10, 32'h0, "cfg0_reset");
    // hardware edge routed to tim2 on
    wr(8'h10, 32'h0c);
    wr(8'h00, 32'h1);
    clr_cnt();
    trig_src[0] = 1;
    tick();
    chk("hw_pulse_hi", 32'(t2on), 32'h1);
    tick();
    chk("hw_pulse_lo", 32'(t2on), 32'h0);
    tick();
    chk("hw_pulse_count", cnt[2], 1);
    rd(8'h08, 32'h1, "hw_status");
    trig_src = 0;
    wr(8'h08, 32'hf);
    // software trigger to tim1 off
    wr(8'h14, 32'h17);
    clr_cnt();
    wr(8'h04, 32'h2);
    chk("sw_not_yet", 32'(t1off), 32'h0);
    tick();
    chk("sw_pulse_hi", 32'(t1off), 32'h1);
    tick();
    chk("sw_pulse_count", cnt[1], 1);
    rd(8'h04, 32'h0, "swtrig_reads_0");
    wr(8'h08, 32'hf);
    // on and off to tim1 from the same edge
    wr(8'h14, 32'h0);
    wr(8'h10, 32'h04);
    wr(8'h18, 32'h14);
    clr_cnt();
    trig_src[0] = 1;
    tick(); tick(); tick();
    chk("coll_on_count", cnt[0], 0);
    chk("coll_off_count", cnt[1], 1);
    rd(8'h08, 32'h5, "coll_status");
    trig_src = 0;
    wr(8'h08, 32'hf);
    // source already high when the channel is enabled
    wr(8'h18, 32'h0);
    wr(8'h10, 32'h0);
    trig_src[1] = 1;
    tick();
    wr(8'h10, 32'h05);
    clr_cnt();
    tick(); tick(); tick();
    chk("held_no_pulse", cnt[0], 0);
    trig_src[1] = 0;
    tick();
    trig_src[1] = 1;
    tick(); tick(); tick();
    chk("fresh_edge_pulse", cnt[0], 1);
    // interrupt and set-over-clear
    trig_src[1] = 0;
    wr(8'h00, 32'h11);
    tick();
    chk("intr_set", 32'(intr), 32'h1);
    bus.psel = 1; bus.pwrite = 1; bus.penable = 0; bus.paddr = 8'h08; bus.pwdata = 32'h1;
    tick();
    bus.penable = 1;
    trig_src[1] = 1;
    tick();
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    rd(8'h08, 32'h1, "set_beats_clear");
    wr(8'h08, 32'h1);
    tick(); tick();
    chk("intr_clear", 32'(intr), 32'h0);
    // reset in the cycle a fire is detected
    trig_src[1] = 0;
    tick();
    clr_cnt();
    trig_src[1] = 1;
    preset = 1;
    tick();
    preset = 0;
    trig_src = 0;
    tick(); tick(); tick();
    chk("reset_drops_pulse", cnt[0], 0);
    rd(8'h00, 32'h0, "ctrl_after_reset");
    rd(8'h08, 32'h0, "status_after_reset");
    rd(8'h10, 32'h0, "cfg0_after_reset");
    rd(8'h18, 32'h0, "cfg2_after_reset");
    // random traffic against the model
    for (int it = 0; it < 400; it++) begin
      trig_src = 4'($urandom);
      a = al[$urandom_range(0, 8)];
      d = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          if (a == 8'h00) d[0] = ($urandom_range(0, 3) != 0);
          wr(a, d);
        end
        3, 4: rd(a, 32'h0, "rand_read", 1);
        5: begin
          preset = ($urandom_range(0, 9) == 0);
          tick();
          preset = 0;
        end
        default: tick();
      endcase
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
